// File: rtl/serial_divisibility_by_n.sv
// Serial divisibility checker for a constant divisor N.
// Bits of an unbounded binary number arrive one per accepted cycle, MSB-first
// or LSB-first, and the running remainder X mod N is kept in a register.
// Each step uses only an add and a single conditional subtract, because the
// intermediate value is always below 2N.
module serial_divisibility_by_n #(
    parameter int N         = 7,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CNT_W     = 16,
    localparam int RW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_bit_valid,
    input  logic             new_bit,
    input  logic             clear,
    output logic [RW-1:0]    remainder,
    output logic             div_by_n,
    output logic [CNT_W-1:0] bit_count,
    output logic             count_sat
);

    generate
        if (N < 2 || N > 255) begin : g_bad_n
            $error("serial_divisibility_by_n: N=%0d outside legal range 2..255", N);
        end
    endgenerate

    localparam logic [RW:0]      N_EXT   = (RW + 1)'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // 2 mod N: the weight of bit 1 when a cleared number starts with a bit.
    localparam int               W_TWO_I = (N <= 2) ? (2 - N) : 2;
    localparam logic [RW-1:0]    W_TWO   = RW'(W_TWO_I);

    logic [RW-1:0]    rem;
    logic [RW-1:0]    w;
    logic [CNT_W-1:0] cnt;

    logic [RW:0]      t;
    logic [RW:0]      t_w;
    logic [RW-1:0]    rem_next;
    logic [RW-1:0]    w_next;

    // Reduce a value known to lie in [0, 2N) into [0, N).
    function automatic logic [RW-1:0] cond_sub(input logic [RW:0] v);
        if (v >= N_EXT) begin
            cond_sub = RW'(v - N_EXT);
        end else begin
            cond_sub = v[RW-1:0];
        end
    endfunction

    // Next remainder and next weight for the bit presented this cycle.
    always_comb begin
        t   = '0;
        t_w = {w, 1'b0};
        if (LSB_FIRST) begin
            t = {1'b0, rem} + (new_bit ? {1'b0, w} : '0);
        end else begin
            t = {rem, new_bit};
        end
        rem_next = cond_sub(t);
        w_next   = cond_sub(t_w);
    end

    // State update: reset beats clear, clear beats a plain accept; a bit that
    // arrives together with clear is bit 0 of the new number.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            w   <= RW'(1);
            cnt <= '0;
        end else if (clear) begin
            if (new_bit_valid) begin
                rem <= RW'(new_bit);
                w   <= W_TWO;
                cnt <= CNT_W'(1);
            end else begin
                rem <= '0;
                w   <= RW'(1);
                cnt <= '0;
            end
        end else if (new_bit_valid) begin
            rem <= rem_next;
            w   <= w_next;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign remainder = rem;
    assign div_by_n  = (rem == '0);
    assign bit_count = cnt;
    assign count_sat = (cnt == CNT_MAX);

endmodule

// File: tb/tb_serial_divisibility_by_n.sv
// Bench for serial_divisibility_by_n: eight instances (N in {3,5,7,10}, MSB and
// LSB order) share one stimulus stream and are compared every cycle against an
// arithmetic model that tracks the actual number X and the bit count.
module tb_serial_divisibility_by_n;

    localparam int NI = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_bit_valid = 1'b0;
    logic new_bit = 1'b0;
    logic clear = 1'b0;

    logic [7:0]  rem_o [NI];
    logic        div_o [NI];
    logic [15:0] cnt_o [NI];
    logic        sat_o [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int n_of(input int i);
        case (i % 4)
            0: n_of = 3;
            1: n_of = 5;
            2: n_of = 7;
            default: n_of = 10;
        endcase
    endfunction

    function automatic bit lsb_of(input int i);
        lsb_of = (i >= 4);
    endfunction

    function automatic int cw_of(input int i);
        cw_of = (i < 4) ? 4 : 16;
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int NV  = (gi % 4 == 0) ? 3 : (gi % 4 == 1) ? 5 : (gi % 4 == 2) ? 7 : 10;
            localparam bit LV  = (gi >= 4);
            localparam int CW  = (gi < 4) ? 4 : 16;
            localparam int RWI = $clog2(NV);
            logic [RWI-1:0] r;
            logic [CW-1:0]  c;
            logic           d;
            logic           s;
            serial_divisibility_by_n #(.N(NV), .LSB_FIRST(LV), .CNT_W(CW)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .new_bit_valid(new_bit_valid),
                .new_bit      (new_bit),
                .clear        (clear),
                .remainder    (r),
                .div_by_n     (d),
                .bit_count    (c),
                .count_sat    (s)
            );
            assign rem_o[gi] = 8'(r);
            assign cnt_o[gi] = 16'(c);
            assign div_o[gi] = d;
            assign sat_o[gi] = s;
        end
    endgenerate

    // Reference model: the number itself, its next bit position, accepted bits.
    longint mx [NI];
    int     mk [NI];
    longint mc [NI];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_bit(input int i, input logic b);
        if (lsb_of(i)) begin
            if (b) mx[i] = mx[i] + (longint'(1) << mk[i]);
            mk[i] = mk[i] + 1;
        end else begin
            mx[i] = 2 * mx[i] + longint'(b);
        end
        mc[i] = mc[i] + 1;
    endfunction

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            longint er, maxc, ec;
            er   = mx[i] % n_of(i);
            maxc = (longint'(1) << cw_of(i)) - 1;
            ec   = (mc[i] > maxc) ? maxc : mc[i];
            check($sformatf("rem[%0d]", i), longint'(rem_o[i]), er);
            check($sformatf("div[%0d]", i), longint'(div_o[i]), longint'(er == 0));
            check($sformatf("cnt[%0d]", i), longint'(cnt_o[i]), ec);
            check($sformatf("sat[%0d]", i), longint'(sat_o[i]), longint'(ec == maxc));
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c, input logic r);
        @(negedge clk);
        new_bit_valid = v;
        new_bit       = b;
        clear         = c;
        rst           = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                mx[i] = 0; mk[i] = 0; mc[i] = 0;
            end else if (c) begin
                mx[i] = 0; mk[i] = 0; mc[i] = 0;
                if (v) model_bit(i, b);
            end else if (v) begin
                model_bit(i, b);
            end
        end
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            mx[i] = 0; mk[i] = 0; mc[i] = 0;
        end

        // Reset state
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_div", longint'(div_o[1]), 1);
        check("reset_cnt", longint'(cnt_o[1]), 0);

        // N=5 MSB: 1,0,1,0 -> remainders 1,2,0,0
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("n5_b0_rem", longint'(rem_o[1]), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("n5_b1_rem", longint'(rem_o[1]), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("n5_b3_rem", longint'(rem_o[1]), 0);
        check("n5_b3_div", longint'(div_o[1]), 1);
        check("n5_b3_cnt", longint'(cnt_o[1]), 4);

        // N=7 LSB: 1,1,1 -> 7 (divisible), then 1 -> 15 mod 7 = 1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("n7l_rem7", longint'(rem_o[6]), 0);
        check("n7l_div7", longint'(div_o[6]), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("n7l_rem15", longint'(rem_o[6]), 1);

        // N=5 MSB with an idle gap, then clear together with a bit
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, k[0], 1'b0, 1'b0);
            check("gap_hold", longint'(rem_o[1]), 1);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_final", longint'(rem_o[1]), 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clrv_rem", longint'(rem_o[1]), 1);
        check("clrv_cnt", longint'(cnt_o[1]), 1);

        // Counter saturation on the CNT_W=4 instances: 17 ones
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat15_cnt", longint'(cnt_o[0]), 15);
        check("sat15_flag", longint'(sat_o[0]), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat17_cnt", longint'(cnt_o[0]), 15);
        check("sat17_rem", longint'(rem_o[0]), 1);

        // Reset mid-number, then continue from X=0
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("midrst_rem", longint'(rem_o[2]), 0);
        check("midrst_div", longint'(div_o[2]), 1);
        check("midrst_cnt", longint'(cnt_o[2]), 0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);

        // Randomised runs with valid gaps
        for (int run = 0; run < 3; run++) begin
            int acc;
            acc = 0;
            step(1'b0, 1'b0, 1'b1, 1'b0);
            while (acc < 16) begin
                logic v;
                v = ($urandom_range(0, 3) != 0);
                step(v, 1'($urandom), 1'b0, 1'b0);
                if (v) acc++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
